tx_ethernet: RTL and testbench

GMII Ethernet II frame transmitter, the transmit-side counterpart of `rx_ethernet` in the Vthernet top. It takes a destination MAC, an EtherType and a byte-stream payload from the upper layer (IPv4/ARP TX path). It emits preamble, SFD, header, payload, zero padding to the 60-byte minimum, and CRC-32 FCS on `TXD`/`TX_EN`/`TX_ER`, then enforces the inter-frame gap. `TX_CLK` is the 125 MHz GMII transmit clock, forwarded by top as `GTX_CLK`.

---
 rtl/tx_ethernet.sv | 199 +++++++++++++++++++
 tb/tb_tx_ethernet.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ethernet.sv
// GMII Ethernet II frame transmitter: preamble/SFD, MAC header, payload with
// zero padding to the minimum size, CRC-32 FCS, then the inter-frame gap.
// Every GMII output is registered from the current state, so an octet chosen
// in a state appears on TXD after the edge that leaves that cycle.
module tx_ethernet #(
  parameter int         OCT         = 8,
  parameter logic [7:0] PRE         = 8'b10101010,
  parameter logic [7:0] SFD         = 8'b10101011,
  parameter int         IFG         = 12,
  parameter int         MIN_PAYLOAD = 46,
  parameter int         MAX_PAYLOAD = 1500
) (
  input  logic           TX_CLK,
  input  logic           rst,
  input  logic [47:0]    mac_addr,
  input  logic [47:0]    tx_dst_mac,
  input  logic [15:0]    tx_ethertype,
  input  logic           tx_start,
  output logic           tx_busy,
  input  logic [OCT-1:0] tx_payload,
  input  logic           tx_payload_valid,
  input  logic           tx_payload_last,
  output logic           tx_payload_ready,
  output logic           tx_done,
  output logic           tx_abort,
  output logic           TX_EN,
  output logic           TX_ER,
  output logic [OCT-1:0] TXD
);

  localparam int HDR_W = 14 * OCT;

  typedef enum logic [3:0] {
    ST_IDLE, ST_PRE, ST_SFD, ST_DST, ST_SRC, ST_TYPE,
    ST_PAYLOAD, ST_PAD, ST_FCS, ST_ERR, ST_GAP
  } state_t;

  state_t             state, state_nxt;
  logic [10:0]        cnt, cnt_nxt;
  logic [HDR_W-1:0]   hdr, hdr_nxt;
  logic [31:0]        crc, crc_nxt, fcs;
  logic [OCT-1:0]     txd_nxt;
  logic               en_nxt, er_nxt, busy_nxt, done_nxt, abort_nxt, crc_upd;

  // Reflected CRC-32 (0xEDB88320), one octet LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [OCT-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < OCT; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign tx_payload_ready = (state == ST_PAYLOAD);
  assign fcs              = ~crc;

  // Next state, counters and the octet to load on the coming edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hdr_nxt   = hdr;
    crc_nxt   = crc;
    crc_upd   = 1'b0;
    txd_nxt   = '0;
    en_nxt    = 1'b0;
    er_nxt    = 1'b0;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (tx_start) begin
          // Header is latched once so upstream may change it mid-frame.
          hdr_nxt   = {tx_dst_mac, mac_addr, tx_ethertype};
          crc_nxt   = '1;
          state_nxt = ST_PRE;
        end
      end
      ST_PRE: begin
        txd_nxt = PRE;
        en_nxt  = 1'b1;
        cnt_nxt = cnt + 11'd1;
        if (cnt == 11'd6) begin
          cnt_nxt   = '0;
          state_nxt = ST_SFD;
        end
      end
      ST_SFD: begin
        txd_nxt   = SFD;
        en_nxt    = 1'b1;
        state_nxt = ST_DST;
      end
      ST_DST, ST_SRC, ST_TYPE: begin
        // DST, SRC and TYPE shift out of one register, MSB octet first.
        txd_nxt = hdr[HDR_W-1 -: OCT];
        hdr_nxt = hdr << OCT;
        en_nxt  = 1'b1;
        crc_upd = 1'b1;
        cnt_nxt = cnt + 11'd1;
        if (state == ST_DST && cnt == 11'd5) begin
          cnt_nxt   = '0;
          state_nxt = ST_SRC;
        end else if (state == ST_SRC && cnt == 11'd5) begin
          cnt_nxt   = '0;
          state_nxt = ST_TYPE;
        end else if (state == ST_TYPE && cnt == 11'd1) begin
          cnt_nxt   = '0;
          state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        en_nxt = 1'b1;
        // A missing byte or one past the maximum size poisons the frame.
        if (!tx_payload_valid || cnt == 11'(MAX_PAYLOAD)) begin
          er_nxt    = 1'b1;
          abort_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_ERR;
        end else begin
          txd_nxt = tx_payload;
          crc_upd = 1'b1;
          cnt_nxt = cnt + 11'd1;
          if (tx_payload_last) begin
            if (cnt + 11'd1 < 11'(MIN_PAYLOAD)) begin
              state_nxt = ST_PAD;
            end else begin
              cnt_nxt   = '0;
              state_nxt = ST_FCS;
            end
          end
        end
      end
      ST_PAD: begin
        en_nxt  = 1'b1;
        crc_upd = 1'b1;
        cnt_nxt = cnt + 11'd1;
        if (cnt + 11'd1 >= 11'(MIN_PAYLOAD)) begin
          cnt_nxt   = '0;
          state_nxt = ST_FCS;
        end
      end
      ST_FCS: begin
        txd_nxt = fcs[{cnt[1:0], 3'b000} +: 8];
        en_nxt  = 1'b1;
        cnt_nxt = cnt + 11'd1;
        if (cnt == 11'd3) begin
          cnt_nxt   = '0;
          state_nxt = ST_GAP;
        end
      end
      ST_ERR: begin
        // This edge already idles the line, so it is gap octet one.
        cnt_nxt   = 11'd1;
        state_nxt = ST_GAP;
      end
      ST_GAP: begin
        // Only the FCS path enters the gap with cnt==0.
        done_nxt = (cnt == 11'd0);
        cnt_nxt  = cnt + 11'd1;
        // The IDLE edge that accepts the next request is the last gap octet.
        if (cnt >= 11'(IFG - 2)) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (crc_upd) crc_nxt = crc_byte(crc, txd_nxt);
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State, datapath and registered GMII/status outputs.
  always_ff @(posedge TX_CLK) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hdr      <= '0;
      crc      <= '0;
      TXD      <= '0;
      TX_EN    <= 1'b0;
      TX_ER    <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hdr      <= hdr_nxt;
      crc      <= crc_nxt;
      TXD      <= txd_nxt;
      TX_EN    <= en_nxt;
      TX_ER    <= er_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
      tx_abort <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_tx_ethernet.sv
// Directed bench for tx_ethernet: table of frame scenarios plus hand-written
// sequences for back-to-back gaps, abort recovery, ignored start and reset.
module tb_tx_ethernet;

  localparam logic [47:0] MAC = 48'h0200_0000_0001;

  logic        TX_CLK = 1'b0;
  logic        rst = 1'b0;
  logic [47:0] mac_addr = MAC;
  logic [47:0] tx_dst_mac = '0;
  logic [15:0] tx_ethertype = '0;
  logic        tx_start = 1'b0;
  logic        tx_busy;
  logic [7:0]  tx_payload = '0;
  logic        tx_payload_valid = 1'b0;
  logic        tx_payload_last = 1'b0;
  logic        tx_payload_ready, tx_done, tx_abort, TX_EN, TX_ER;
  logic [7:0]  TXD;

  tx_ethernet dut (
    .TX_CLK(TX_CLK), .rst(rst), .mac_addr(mac_addr), .tx_dst_mac(tx_dst_mac),
    .tx_ethertype(tx_ethertype), .tx_start(tx_start), .tx_busy(tx_busy),
    .tx_payload(tx_payload), .tx_payload_valid(tx_payload_valid),
    .tx_payload_last(tx_payload_last), .tx_payload_ready(tx_payload_ready),
    .tx_done(tx_done), .tx_abort(tx_abort), .TX_EN(TX_EN), .TX_ER(TX_ER), .TXD(TXD)
  );

  always #4 TX_CLK = ~TX_CLK;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor, sampled 1 ns after each rising edge.
  logic [7:0] oct_q[$];
  int gap_q[$];
  int er_cnt = 0, done_cnt = 0, abort_cnt = 0, bad_done = 0, bad_abort = 0, idle_run = 0;
  logic prev_en = 1'b0;

  always @(posedge TX_CLK) begin
    #1;
    if (TX_EN) oct_q.push_back(TXD);
    if (TX_ER) er_cnt++;
    if (tx_done) done_cnt++;
    if (tx_abort) abort_cnt++;
    if (tx_done && (TX_EN || !prev_en)) bad_done++;
    if (tx_abort != TX_ER) bad_abort++;
    if (TX_EN && !prev_en) gap_q.push_back(idle_run);
    idle_run = TX_EN ? 0 : idle_run + 1;
    prev_en  = TX_EN;
  end

  int b_oct, b_gap, b_er, b_done, b_abort;
  task automatic snap;
    b_oct = oct_q.size(); b_gap = gap_q.size(); b_er = er_cnt;
    b_done = done_cnt; b_abort = abort_cnt;
  endtask

  function automatic int gap_at(input int i);
    return (gap_q.size() > i) ? gap_q[i] : -1;
  endfunction

  function automatic logic [7:0] exp_oct(input logic [47:0] dst, input logic [15:0] et,
                                         input int len, input int i);
    logic [111:0] h;
    logic [111:0] t;
    int k;
    h = {dst, MAC, et};
    k = i - 22;
    if (i < 7) return 8'hAA;
    if (i == 7) return 8'hAB;
    if (i < 22) begin
      t = h >> (8 * (21 - i));
      return t[7:0];
    end
    return (k < len) ? k[7:0] : 8'h00;
  endfunction

  function automatic logic [31:0] residue(input int from, input int to);
    logic [31:0] c;
    logic [7:0] d;
    c = 32'hFFFF_FFFF;
    for (int i = from; i < to; i++) begin
      d = oct_q[i];
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ d[b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Present payload byte k (value k) whenever the block is ready.
  task automatic feed(input int len, input int drop_at, input bit use_last);
    int k, g;
    bit dropped;
    k = 0; g = 0; dropped = 0;
    while (!tx_payload_ready && g < 60) begin
      @(negedge TX_CLK);
      g++;
    end
    if (!tx_payload_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got 0 expected 1 within 60 cycles");
      return;
    end
    g = 0;
    while (tx_payload_ready && k < len && g < 4000) begin
      if (k == drop_at && !dropped) begin
        tx_payload_valid = 1'b0;
        dropped = 1;
      end else begin
        tx_payload_valid = 1'b1;
        tx_payload       = k[7:0];
        tx_payload_last  = use_last && (k == len - 1);
      end
      @(negedge TX_CLK);
      if (tx_payload_valid) k++;
      g++;
    end
    tx_payload_valid = 1'b0;
    tx_payload_last  = 1'b0;
  endtask

  task automatic wait_idle;
    int g;
    g = 0;
    while (tx_busy && g < 2000) begin
      @(negedge TX_CLK);
      g++;
    end
    if (tx_busy) begin
      checks++; errors++;
      $display("FAIL busy_timeout: got 1 expected 0 within 2000 cycles");
    end
    repeat (2) @(negedge TX_CLK);
  endtask

  typedef struct {
    logic [47:0] dst;
    logic [15:0] etype;
    int          len;
    int          drop_at;
    bit          use_last;
    int          exp_en;
    int          exp_done;
    int          exp_abort;
    int          exp_er;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, lim, mism;
    logic [7:0] e;

    vecs[0] = '{48'hFFFF_FFFF_FFFF, 16'h0806,   28, -1, 1'b1,   72, 1, 0, 0};
    vecs[1] = '{48'h0011_2233_4455, 16'h0800,  100, -1, 1'b1,  126, 1, 0, 0};
    vecs[2] = '{48'h0A0B_0C0D_0E0F, 16'h86DD,    1, -1, 1'b1,   72, 1, 0, 0};
    vecs[3] = '{48'h1234_5678_9ABC, 16'h0800,   46, -1, 1'b1,   72, 1, 0, 0};
    vecs[4] = '{48'h1234_5678_9ABC, 16'h0800,   47, -1, 1'b1,   73, 1, 0, 0};
    vecs[5] = '{48'hA1A2_A3A4_A5A6, 16'h0806,   45, -1, 1'b1,   72, 1, 0, 0};
    vecs[6] = '{48'hFFFF_FFFF_FFFF, 16'h0800,   28, 10, 1'b1,   33, 0, 1, 1};
    vecs[7] = '{48'h0011_2233_4455, 16'h0800, 1501, -1, 1'b0, 1523, 0, 1, 1};

    // Reset state
    repeat (3) @(negedge TX_CLK);
    chk("reset_outputs", {TX_EN, TX_ER, TXD, tx_busy, tx_payload_ready, tx_done, tx_abort}, 0);
    rst = 1'b1;
    repeat (2) @(negedge TX_CLK);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      snap();
      tx_dst_mac = vecs[v].dst; tx_ethertype = vecs[v].etype; tx_start = 1'b1;
      @(negedge TX_CLK);
      tx_start = 1'b0;
      feed(vecs[v].len, vecs[v].drop_at, vecs[v].use_last);
      wait_idle();
      n = oct_q.size() - b_oct;
      chk($sformatf("v%0d_en_cycles", v), n, vecs[v].exp_en);
      chk($sformatf("v%0d_done", v), done_cnt - b_done, vecs[v].exp_done);
      chk($sformatf("v%0d_abort", v), abort_cnt - b_abort, vecs[v].exp_abort);
      chk($sformatf("v%0d_tx_er", v), er_cnt - b_er, vecs[v].exp_er);
      lim = vecs[v].exp_abort ? n : n - 4;
      mism = 0;
      for (int i = 0; i < lim; i++) begin
        e = (vecs[v].exp_abort && i == n - 1) ? 8'h00
            : exp_oct(vecs[v].dst, vecs[v].etype, vecs[v].len, i);
        if (oct_q[b_oct + i] !== e) mism++;
      end
      chk($sformatf("v%0d_octets", v), mism, 0);
      if (vecs[v].exp_done == 1)
        chk($sformatf("v%0d_crc_residue", v), residue(b_oct + 8, b_oct + n), 32'hDEBB20E3);
    end
    chk("done_alignment", bad_done, 0);
    chk("abort_er_alignment", bad_abort, 0);

    // Back-to-back: start held for three 46-byte frames
    snap();
    tx_dst_mac = 48'hFFFF_FFFF_FFFF; tx_ethertype = 16'h0800;
    @(negedge TX_CLK);
    tx_start = 1'b1;
    feed(46, -1, 1);
    feed(46, -1, 1);
    feed(46, -1, 1);
    tx_start = 1'b0;
    wait_idle();
    repeat (20) @(negedge TX_CLK);
    chk("b2b_frames", gap_q.size() - b_gap, 3);
    chk("b2b_gap1", gap_at(b_gap + 1), 12);
    chk("b2b_gap2", gap_at(b_gap + 2), 12);
    chk("b2b_done", done_cnt - b_done, 3);

    // Abort then next frame with start held: gap still exactly 12
    snap();
    tx_start = 1'b1;
    feed(28, 10, 1);
    feed(46, -1, 1);
    tx_start = 1'b0;
    wait_idle();
    chk("abort_gap", gap_at(b_gap + 1), 12);
    chk("abort_then_done", {abort_cnt - b_abort, done_cnt - b_done}, {32'd1, 32'd1});

    // Start pulsed mid-frame is ignored
    snap();
    tx_start = 1'b1;
    @(negedge TX_CLK);
    tx_start = 1'b0;
    repeat (10) @(negedge TX_CLK);
    tx_start = 1'b1;
    @(negedge TX_CLK);
    tx_start = 1'b0;
    feed(20, -1, 1);
    wait_idle();
    repeat (30) @(negedge TX_CLK);
    chk("midframe_start_frames", gap_q.size() - b_gap, 1);

    // Start-to-output latency, then reset at payload byte 20
    snap();
    tx_dst_mac = 48'hC0FF_EE12_3456; tx_ethertype = 16'h0800; tx_start = 1'b1;
    @(negedge TX_CLK);                       // after edge N
    tx_start = 1'b0;
    chk("lat_en_after_N", TX_EN, 1'b0);
    @(negedge TX_CLK);                       // after N+1
    chk("lat_pre_after_N1", {tx_busy, TX_EN, TXD}, {1'b1, 1'b1, 8'hAA});
    repeat (8) @(negedge TX_CLK);            // after N+9
    chk("lat_dst_after_N9", TXD, 8'hC0);
    repeat (12) @(negedge TX_CLK);           // after N+21
    chk("lat_ready_N21", tx_payload_ready, 1'b0);
    @(negedge TX_CLK);                       // after N+22
    chk("lat_ready_N22", tx_payload_ready, 1'b1);
    feed(20, -1, 1'b0);
    rst = 1'b0;
    @(negedge TX_CLK);
    chk("midframe_reset_outputs",
        {TX_EN, TX_ER, TXD, tx_busy, tx_payload_ready, tx_done, tx_abort}, 0);
    @(negedge TX_CLK);
    rst = 1'b1; tx_start = 1'b1;
    @(negedge TX_CLK);
    tx_start = 1'b0;
    @(negedge TX_CLK);
    chk("post_reset_pre", {TX_EN, TXD}, {1'b1, 8'hAA});
    feed(46, -1, 1);
    wait_idle();
    chk("post_reset_done", {abort_cnt - b_abort, done_cnt - b_done}, {32'd0, 32'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
